// File: rtl/data_cache.sv
// Direct-mapped, write-through, no-write-allocate data cache with 4-word lines.
// Read hits complete combinationally; misses fill the line over the shared bus.
// Optional build macro DATA_CACHE_UNCACHED_EN: addr[31]=1 bypasses the cache.
module data_cache #(
    parameter int unsigned LINES      = 64,
    parameter int unsigned LINE_WORDS = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] addr,
    input  logic        rd_req,
    input  logic        wr_req,
    input  logic [31:0] wr_data,
    output logic [31:0] rd_data,
    output logic        rw_wait,
    output logic        bus_req,
    input  logic        bus_ack,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    output logic        bus_rd,
    output logic        bus_wr,
    input  logic [31:0] bus_rdata,
    input  logic        bus_ready
);
    localparam int unsigned IW = $clog2(LINES);
    localparam int unsigned TW = 28 - IW;
    localparam logic [1:0] LAST_WORD = 2'(LINE_WORDS - 1);

    typedef enum logic [1:0] {S_IDLE, S_FILL, S_WRITE, S_UNC_RD} state_t;

    state_t          state_q, state_d;
    logic [1:0]      cnt_q, cnt_d;
    logic [IW-1:0]   fill_idx_q, fill_idx_d;
    logic [TW-1:0]   fill_tag_q, fill_tag_d;
    logic [LINES-1:0] valid_q, valid_d;
    logic            bus_req_q, bus_req_d;

    logic [TW-1:0]   tag_mem  [LINES-1:0];
    logic [31:0]     data_mem [LINES-1:0][LINE_WORDS-1:0];

    logic [1:0]      word;
    logic [IW-1:0]   index;
    logic [TW-1:0]   tag;
    logic            uncached;
    logic            hit;
    logic            xfer;
    logic            mem_we;
    logic [IW-1:0]   mem_idx;
    logic [1:0]      mem_word;
    logic [31:0]     mem_wdata;
    logic            tag_we;
    logic            unused_addr_bits;

    assign word  = addr[3:2];
    assign index = addr[4 +: IW];
    assign tag   = addr[31 -: TW];
    assign unused_addr_bits = ^addr[1:0];

`ifdef DATA_CACHE_UNCACHED_EN
    assign uncached = addr[31];
`else
    assign uncached = 1'b0;
`endif

    assign hit     = valid_q[index] && (tag_mem[index] == tag) && !uncached;
    assign xfer    = bus_ack && bus_ready;
    assign bus_req = bus_req_q;

    // Next-state logic: FSM transitions, fill counter, valid bits and array write enables
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        fill_idx_d = fill_idx_q;
        fill_tag_d = fill_tag_q;
        valid_d    = valid_q;
        bus_req_d  = bus_req_q;
        mem_we     = 1'b0;
        mem_idx    = index;
        mem_word   = word;
        mem_wdata  = wr_data;
        tag_we     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (wr_req) begin
                    state_d   = S_WRITE;
                    bus_req_d = 1'b1;
                end else if (rd_req && uncached) begin
                    state_d   = S_UNC_RD;
                    bus_req_d = 1'b1;
                end else if (rd_req && !hit) begin
                    // Line is invalidated up front so a partial fill never looks valid
                    state_d        = S_FILL;
                    bus_req_d      = 1'b1;
                    cnt_d          = '0;
                    fill_idx_d     = index;
                    fill_tag_d     = tag;
                    valid_d[index] = 1'b0;
                end
            end
            S_FILL: begin
                if (xfer) begin
                    mem_we    = 1'b1;
                    mem_idx   = fill_idx_q;
                    mem_word  = cnt_q;
                    mem_wdata = bus_rdata;
                    cnt_d     = cnt_q + 2'd1;
                    if (cnt_q == LAST_WORD) begin
                        valid_d[fill_idx_q] = 1'b1;
                        tag_we    = 1'b1;
                        cnt_d     = '0;
                        state_d   = S_IDLE;
                        bus_req_d = 1'b0;
                    end
                end
            end
            S_WRITE: begin
                if (xfer) begin
                    mem_we    = hit;
                    state_d   = S_IDLE;
                    bus_req_d = 1'b0;
                end
            end
            S_UNC_RD: begin
                if (xfer) begin
                    state_d   = S_IDLE;
                    bus_req_d = 1'b0;
                end
            end
            default: ;
        endcase
    end

    // Bus drive: everything forced to zero without a grant because the bus is wired-OR
    always_comb begin
        bus_rd    = 1'b0;
        bus_wr    = 1'b0;
        bus_addr  = '0;
        bus_wdata = '0;
        if (bus_ack) begin
            case (state_q)
                S_FILL: begin
                    bus_rd   = 1'b1;
                    bus_addr = {fill_tag_q, fill_idx_q, cnt_q, 2'b00};
                end
                S_WRITE: begin
                    bus_wr    = 1'b1;
                    bus_addr  = {addr[31:2], 2'b00};
                    bus_wdata = wr_data;
                end
                S_UNC_RD: begin
                    bus_rd   = 1'b1;
                    bus_addr = {addr[31:2], 2'b00};
                end
                default: ;
            endcase
        end
    end

    // Core handshake: writes win over reads; hits and write completion release the stall
    always_comb begin
        rw_wait = 1'b0;
        rd_data = '0;
        if (wr_req) begin
            rw_wait = !((state_q == S_WRITE) && xfer);
        end else if (rd_req) begin
            case (state_q)
                S_IDLE: begin
                    rw_wait = !hit;
                    rd_data = hit ? data_mem[index][word] : '0;
                end
                S_UNC_RD: begin
                    rw_wait = !xfer;
                    rd_data = xfer ? bus_rdata : '0;
                end
                default: rw_wait = 1'b1;
            endcase
        end
    end

    // Control state; reset aborts any transfer and invalidates every line
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            fill_idx_q <= '0;
            fill_tag_q <= '0;
            valid_q    <= '0;
            bus_req_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            fill_idx_q <= fill_idx_d;
            fill_tag_q <= fill_tag_d;
            valid_q    <= valid_d;
            bus_req_q  <= bus_req_d;
        end
    end

    // Tag and data arrays carry no reset; valid bits gate their use
    always_ff @(posedge clk) begin
        if (mem_we) begin
            data_mem[mem_idx][mem_word] <= mem_wdata;
        end
        if (tag_we) begin
            tag_mem[fill_idx_q] <= fill_tag_q;
        end
    end
endmodule

// File: tb/tb_data_cache.sv
// Self-checking bench for data_cache: directed scenarios plus randomized accesses
// compared against a line-residency model and a sparse bus memory.
module tb_data_cache;
    localparam int unsigned LINES = 64;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] addr;
    logic        rd_req;
    logic        wr_req;
    logic [31:0] wr_data;
    logic [31:0] rd_data;
    logic        rw_wait;
    logic        bus_req;
    logic        bus_ack;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic        bus_rd;
    logic        bus_wr;
    logic [31:0] bus_rdata;
    logic        bus_ready;

    always #5 clk = ~clk;

    data_cache #(.LINES(LINES), .LINE_WORDS(4)) dut (
        .clk(clk), .rst(rst), .addr(addr), .rd_req(rd_req), .wr_req(wr_req),
        .wr_data(wr_data), .rd_data(rd_data), .rw_wait(rw_wait), .bus_req(bus_req),
        .bus_ack(bus_ack), .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_rd(bus_rd),
        .bus_wr(bus_wr), .bus_rdata(bus_rdata), .bus_ready(bus_ready)
    );

    int checks = 0;
    int failures = 0;

    // Bus memory (sparse, hashed default) and cache residency: index -> line number addr[31:4]
    logic [31:0] mem [logic [31:0]];
    logic [27:0] resident [int unsigned];

    typedef struct packed {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
    } xfer_t;
    xfer_t xq[$];

    function automatic logic [31:0] memval(input logic [31:0] a);
        logic [31:0] k;
        k = {a[31:2], 2'b00};
        if (mem.exists(k)) return mem[k];
        return (k * 32'h9E3779B1) ^ 32'h0BADF00D;
    endfunction

    function automatic int unsigned idx_of(input logic [31:0] a);
        return (a >> 4) % LINES;
    endfunction

    function automatic bit model_hit(input logic [31:0] a);
        int unsigned i;
        i = idx_of(a);
        return resident.exists(i) && (resident[i] == a[31:4]);
    endfunction

    // Drives one core access and plays the bus; records completed bus transfers in xq
    task automatic run_access(input bit wr, input bit rd_too, input logic [31:0] a,
                              input logic [31:0] wd, input int ack_dly, input int rdy_dly,
                              input int withdraw_at, output int cycles,
                              output logic [31:0] rdata, output bit saw_req,
                              output bit idle_bad);
        int req_cyc;
        int ack_cnt;
        bit active;
        req_cyc = 0; ack_cnt = 0; active = 1'b1;
        xq.delete();
        cycles = 0; rdata = '0; saw_req = 1'b0; idle_bad = 1'b0;
        @(posedge clk); #1;
        addr = a; wr_data = wd; wr_req = wr; rd_req = !wr || rd_too;
        forever begin
            cycles++;
            if (withdraw_at != 0 && cycles == withdraw_at) begin
                rd_req = 1'b0; wr_req = 1'b0; active = 1'b0;
            end
            bus_ack = bus_req && (req_cyc >= ack_dly);
            #1;
            bus_ready = bus_ack ? (ack_cnt >= rdy_dly) : 1'($urandom_range(0, 1));
            bus_rdata = bus_ack ? memval(bus_addr) : $urandom;
            #1;
            if (bus_req) saw_req = 1'b1;
            if (!bus_ack && (bus_rd || bus_wr || bus_addr != 0 || bus_wdata != 0)) idle_bad = 1'b1;
            if (bus_ack && bus_ready) begin
                xq.push_back('{wr: bus_wr, addr: bus_addr, wdata: bus_wdata});
                if (bus_wr) mem[bus_addr] = bus_wdata;
            end
            if (active && !rw_wait) begin
                rdata = rd_data;
                break;
            end
            if (!active && !bus_req) break;
            if (cycles > 200) begin
                cycles = -1;
                break;
            end
            if (bus_ack) ack_cnt = bus_ready ? 0 : ack_cnt + 1;
            req_cyc = bus_req ? req_cyc + 1 : 0;
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
        rd_req = 1'b0; wr_req = 1'b0; bus_ack = 1'b0; bus_ready = 1'b0; bus_rdata = '0;
    endtask

    task automatic test_reset();
        rst = 1'b1; rd_req = 1'b0; wr_req = 1'b0; addr = '0; wr_data = '0;
        bus_ack = 1'b1; bus_ready = 1'b1; bus_rdata = 32'hFFFFFFFF;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (bus_req !== 1'b0) begin failures++; $display("FAIL reset_bus_req: got %b expected 0", bus_req); end
        checks++; if ({bus_rd, bus_wr, bus_addr, bus_wdata} !== '0) begin failures++;
            $display("FAIL reset_bus_outputs: got rd=%b wr=%b addr=%h wdata=%h expected all zero", bus_rd, bus_wr, bus_addr, bus_wdata); end
        checks++; if (rw_wait !== 1'b0 || rd_data !== '0) begin failures++;
            $display("FAIL reset_idle_core: got rw_wait=%b rd_data=%h expected 0/0", rw_wait, rd_data); end
        addr = 32'h100; rd_req = 1'b1; #1;
        checks++; if (rw_wait !== 1'b1) begin failures++; $display("FAIL reset_read_miss: got rw_wait=%b expected 1", rw_wait); end
        @(posedge clk); #1;
        rd_req = 1'b0; bus_ack = 1'b0; bus_ready = 1'b0; bus_rdata = '0; rst = 1'b0;
        resident.delete();
    endtask

    task automatic test_fill();
        int cyc; logic [31:0] rd; bit sr, ib;
        for (int i = 0; i < 4; i++) mem[32'h100 + 32'(4 * i)] = 32'hA0 + 32'(i);
        run_access(1'b0, 1'b0, 32'h100, '0, 0, 0, 0, cyc, rd, sr, ib);
        resident[idx_of(32'h100)] = 28'h10;
        checks++; if (cyc !== 6) begin failures++; $display("FAIL fill_cycles: got %0d expected 6", cyc); end
        checks++; if (xq.size() !== 4) begin failures++; $display("FAIL fill_xfers: got %0d expected 4", xq.size()); end
        for (int i = 0; i < xq.size() && i < 4; i++) begin
            checks++;
            if (xq[i].wr !== 1'b0 || xq[i].addr !== 32'h100 + 32'(4 * i)) begin failures++;
                $display("FAIL fill_addr%0d: got wr=%b addr=%h expected read at %h", i, xq[i].wr, xq[i].addr, 32'h100 + 32'(4 * i)); end
        end
        checks++; if (rd !== 32'hA0) begin failures++; $display("FAIL fill_rdata: got %h expected 000000a0", rd); end
        checks++; if (ib !== 1'b0) begin failures++; $display("FAIL fill_bus_idle: got nonzero bus outputs without grant, expected zero"); end
    endtask

    task automatic test_hit();
        int cyc; logic [31:0] rd; bit sr, ib;
        run_access(1'b0, 1'b0, 32'h108, '0, 0, 0, 0, cyc, rd, sr, ib);
        checks++; if (cyc !== 1) begin failures++; $display("FAIL hit_cycles: got %0d expected 1", cyc); end
        checks++; if (rd !== 32'hA2) begin failures++; $display("FAIL hit_rdata: got %h expected 000000a2", rd); end
        checks++; if (sr !== 1'b0) begin failures++; $display("FAIL hit_bus_req: got %b expected 0", sr); end
    endtask

    task automatic test_write();
        int cyc; logic [31:0] rd; bit sr, ib;
        run_access(1'b1, 1'b0, 32'h104, 32'hDEADBEEF, 0, 2, 0, cyc, rd, sr, ib);
        checks++; if (cyc !== 4) begin failures++; $display("FAIL write_cycles: got %0d expected 4", cyc); end
        checks++; if (xq.size() !== 1) begin failures++; $display("FAIL write_xfers: got %0d expected 1", xq.size()); end
        else begin
            checks++; if (xq[0].wr !== 1'b1 || xq[0].addr !== 32'h104 || xq[0].wdata !== 32'hDEADBEEF) begin failures++;
                $display("FAIL write_bus: got wr=%b addr=%h wdata=%h expected 1/00000104/deadbeef", xq[0].wr, xq[0].addr, xq[0].wdata); end
        end
        run_access(1'b0, 1'b0, 32'h104, '0, 0, 0, 0, cyc, rd, sr, ib);
        checks++; if (cyc !== 1 || rd !== 32'hDEADBEEF) begin failures++;
            $display("FAIL write_readback: got cycles=%0d data=%h expected 1/deadbeef", cyc, rd); end
    endtask

    task automatic test_ack_delay();
        int cyc; logic [31:0] rd; bit sr, ib;
        run_access(1'b0, 1'b0, 32'h200, '0, 3, 0, 0, cyc, rd, sr, ib);
        resident[idx_of(32'h200)] = 28'h20;
        checks++; if (sr !== 1'b1) begin failures++; $display("FAIL ackdly_bus_req: got %b expected 1", sr); end
        checks++; if (ib !== 1'b0) begin failures++; $display("FAIL ackdly_bus_idle: got nonzero bus outputs without grant, expected zero"); end
        checks++; if (cyc !== 9) begin failures++; $display("FAIL ackdly_cycles: got %0d expected 9", cyc); end
        checks++; if (xq.size() !== 4 || rd !== memval(32'h200)) begin failures++;
            $display("FAIL ackdly_fill: got xfers=%0d data=%h expected 4/%h", xq.size(), rd, memval(32'h200)); end
    endtask

    task automatic test_replace();
        int cyc; logic [31:0] rd; bit sr, ib;
        run_access(1'b0, 1'b0, 32'h500, '0, 0, 0, 0, cyc, rd, sr, ib);
        resident[idx_of(32'h500)] = 28'h50;
        checks++; if (cyc !== 6 || xq.size() !== 4) begin failures++;
            $display("FAIL replace_miss: got cycles=%0d xfers=%0d expected 6/4", cyc, xq.size()); end
        checks++; if (xq.size() > 0 && xq[0].addr !== 32'h500) begin failures++;
            $display("FAIL replace_addr: got %h expected 00000500", xq[0].addr); end
        checks++; if (rd !== memval(32'h500)) begin failures++; $display("FAIL replace_rdata: got %h expected %h", rd, memval(32'h500)); end
        run_access(1'b0, 1'b0, 32'h100, '0, 0, 0, 0, cyc, rd, sr, ib);
        resident[idx_of(32'h100)] = 28'h10;
        checks++; if (cyc !== 6 || rd !== 32'hA0) begin failures++;
            $display("FAIL replace_old_misses: got cycles=%0d data=%h expected 6/000000a0", cyc, rd); end
    endtask

    task automatic test_rd_wr_both();
        int cyc; logic [31:0] rd; bit sr, ib;
        run_access(1'b1, 1'b1, 32'h108, 32'h55AA55AA, 0, 0, 0, cyc, rd, sr, ib);
        checks++; if (cyc !== 2 || xq.size() !== 1) begin failures++;
            $display("FAIL both_write: got cycles=%0d xfers=%0d expected 2/1", cyc, xq.size()); end
        checks++; if (xq.size() > 0 && xq[0].wr !== 1'b1) begin failures++; $display("FAIL both_is_write: got wr=%b expected 1", xq[0].wr); end
        run_access(1'b0, 1'b0, 32'h108, '0, 0, 0, 0, cyc, rd, sr, ib);
        checks++; if (cyc !== 1 || rd !== 32'h55AA55AA) begin failures++;
            $display("FAIL both_readback: got cycles=%0d data=%h expected 1/55aa55aa", cyc, rd); end
    endtask

    task automatic test_idle();
        @(posedge clk); #3;
        checks++; if (rw_wait !== 1'b0 || rd_data !== '0 || bus_req !== 1'b0) begin failures++;
            $display("FAIL idle_outputs: got rw_wait=%b rd_data=%h bus_req=%b expected 0/0/0", rw_wait, rd_data, bus_req); end
    endtask

    task automatic test_withdraw();
        int cyc; logic [31:0] rd; bit sr, ib;
        run_access(1'b0, 1'b0, 32'h2340, '0, 0, 1, 3, cyc, rd, sr, ib);
        resident[idx_of(32'h2340)] = 28'h234;
        checks++; if (cyc < 0 || xq.size() !== 4) begin failures++;
            $display("FAIL withdraw_fill: got cycles=%0d xfers=%0d expected 4 transfers", cyc, xq.size()); end
        run_access(1'b0, 1'b0, 32'h234C, '0, 0, 0, 0, cyc, rd, sr, ib);
        checks++; if (cyc !== 1 || rd !== memval(32'h234C)) begin failures++;
            $display("FAIL withdraw_hit: got cycles=%0d data=%h expected 1/%h", cyc, rd, memval(32'h234C)); end
    endtask

    task automatic test_reset_mid_fill();
        int cyc; int n; logic [31:0] rd; bit sr, ib;
        run_access(1'b0, 1'b0, 32'h900, '0, 0, 0, 0, cyc, rd, sr, ib);
        resident[idx_of(32'h900)] = 28'h90;
        n = 0;
        @(posedge clk); #1;
        addr = 32'h100; rd_req = 1'b1;
        for (int i = 0; i < 50; i++) begin
            bus_ack = bus_req; #1;
            bus_ready = bus_ack; bus_rdata = bus_ack ? memval(bus_addr) : '0; #1;
            if (bus_ack && bus_ready) n++;
            if (n == 2) break;
            @(posedge clk); #1;
        end
        checks++; if (n !== 2) begin failures++; $display("FAIL midrst_progress: got %0d transfers expected 2", n); end
        @(posedge clk); #1;
        checks++; if (bus_req !== 1'b1) begin failures++; $display("FAIL midrst_pre: got bus_req=%b expected 1", bus_req); end
        rst = 1'b1; #1;
        checks++; if (bus_req !== 1'b0 || bus_rd !== 1'b0 || bus_addr !== '0) begin failures++;
            $display("FAIL midrst_abort: got bus_req=%b bus_rd=%b bus_addr=%h expected 0/0/0", bus_req, bus_rd, bus_addr); end
        resident.delete();
        @(posedge clk); #1;
        rst = 1'b0; rd_req = 1'b0; bus_ack = 1'b0; bus_ready = 1'b0; bus_rdata = '0;
        run_access(1'b0, 1'b0, 32'h100, '0, 0, 0, 0, cyc, rd, sr, ib);
        resident[idx_of(32'h100)] = 28'h10;
        checks++; if (cyc !== 6 || xq.size() !== 4 || rd !== 32'hA0) begin failures++;
            $display("FAIL midrst_refetch: got cycles=%0d xfers=%0d data=%h expected 6/4/000000a0", cyc, xq.size(), rd); end
    endtask

    task automatic test_random();
        int cyc; int exp_cyc; int ad; int rdl; logic [31:0] rd; logic [31:0] a; logic [31:0] wd;
        bit sr, ib, wr, both, hit;
        for (int t = 0; t < 80; t++) begin
            a = (32'($urandom_range(0, 1)) << 31) | (32'($urandom_range(0, 2)) << 10) |
                (32'($urandom_range(0, 3)) << 4) | ($urandom & 32'hF);
            wd = $urandom;
            wr = ($urandom_range(0, 2) == 0);
            both = 1'($urandom_range(0, 1));
            ad = $urandom_range(0, 2);
            rdl = $urandom_range(0, 2);
            hit = model_hit(a);
            if (wr) exp_cyc = 2 + ad + rdl;
            else if (hit) exp_cyc = 1;
            else exp_cyc = 2 + ad + 4 * (rdl + 1);
            run_access(wr, both, a, wd, ad, rdl, 0, cyc, rd, sr, ib);
            checks++; if (cyc !== exp_cyc) begin failures++;
                $display("FAIL rnd%0d_cycles: addr=%h wr=%b got %0d expected %0d", t, a, wr, cyc, exp_cyc); end
            checks++; if (ib !== 1'b0) begin failures++; $display("FAIL rnd%0d_bus_idle: got nonzero bus outputs without grant, expected zero", t); end
            if (wr) begin
                checks++; if (xq.size() !== 1 || xq[0].wr !== 1'b1 || xq[0].addr !== {a[31:2], 2'b00} || xq[0].wdata !== wd) begin failures++;
                    $display("FAIL rnd%0d_write: got n=%0d expected one write of %h to %h", t, xq.size(), wd, {a[31:2], 2'b00}); end
            end else begin
                checks++; if (rd !== memval(a)) begin failures++;
                    $display("FAIL rnd%0d_rdata: addr=%h got %h expected %h", t, a, rd, memval(a)); end
                checks++; if (xq.size() !== (hit ? 0 : 4)) begin failures++;
                    $display("FAIL rnd%0d_xfers: got %0d expected %0d", t, xq.size(), hit ? 0 : 4); end
                for (int i = 0; i < xq.size() && i < 4; i++) begin
                    checks++; if (xq[i].wr !== 1'b0 || xq[i].addr !== {a[31:4], 2'(i), 2'b00}) begin failures++;
                        $display("FAIL rnd%0d_fill%0d: got addr=%h expected %h", t, i, xq[i].addr, {a[31:4], 2'(i), 2'b00}); end
                end
                if (!hit) resident[idx_of(a)] = a[31:4];
            end
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_fill();
        test_hit();
        test_write();
        test_ack_delay();
        test_replace();
        test_rd_wr_both();
        test_idle();
        test_withdraw();
        test_reset_mid_fill();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/data_cache.md
DATA_CACHE -- requirements
Module: data_cache

Interface
REQ-001 SHALL have parameter LINES, default 64: number of direct-mapped lines; power of two, 16..256.
REQ-002 SHALL have parameter LINE_WORDS, default 4: 32-bit words per line; fixed at 4.
REQ-003 clk  in  1  single clock; all state updates on its rising edge.
REQ-004 rst  in  1  reset; asynchronous and active-high.
REQ-005 addr  in  32  core word address; bits [1:0] ignored.
REQ-006 rd_req  in  1  core read request, held until rw_wait is low.
REQ-007 wr_req  in  1  core write request, held until rw_wait is low.
REQ-008 wr_data  in  32  core write data.
REQ-009 rd_data  out  32  read data, valid when rd_req=1 and rw_wait=0.
REQ-010 rw_wait  out  1  core stall while the request is incomplete.
REQ-011 bus_req  out  1  request to the bus arbiter.
REQ-012 bus_ack  in  1  grant from the arbiter; combinational, held while bus_req stays high.
REQ-013 bus_addr / bus_wdata  out  32 each  bus address / write data.
REQ-014 bus_rd / bus_wr  out  1 each  bus read / write strobes.
REQ-015 bus_rdata  in  32  bus read data, valid with bus_ready.
REQ-016 bus_ready  in  1  bus completes the current transfer this cycle.

Function
REQ-017 Address split SHALL be: word = addr[3:2], index = addr[4+log2(LINES)-1:4], tag = remaining upper bits.
REQ-018 Each line SHALL hold a valid bit, a tag and 4 data words; hit = valid & tag match.
REQ-019 Read hit SHALL be combinational: rw_wait=0 and rd_data = cached word in the same cycle.
REQ-020 Read miss SHALL set rw_wait=1, then FSM IDLE->FILL.
- FILL: bus_req=1.
- While bus_ack=1: bus_rd=1, bus_addr = {tag,index,cnt,2'b00}.
- On each bus_ready: store bus_rdata into word cnt, then cnt++.
- After word 3: set valid, write tag, go to IDLE; the next cycle is a hit.
REQ-021 Write SHALL be write-through, no-write-allocate.
- FSM IDLE->WRITE: bus_req=1.
- While bus_ack=1: bus_wr=1, bus_addr={addr[31:2],2'b00}, bus_wdata=wr_data.
- On bus_ready: update the cached word if hit, return to IDLE, rw_wait=0 in that same cycle.
REQ-022 With wr_req=1, rw_wait SHALL be 1 except in the completing bus_ready cycle.
REQ-023 With bus_ack=0, bus_addr, bus_wdata, bus_rd and bus_wr SHALL be all-zero, because the bus is a wired OR; the FSM pauses, state held.
REQ-024 With rd_req and wr_req both high, the write SHALL be served and rd_req ignored.
REQ-025 If the core withdraws a request mid-fill, the fill SHALL still complete and validate the line.
REQ-026 bus_ready seen without bus_ack SHALL be ignored.
REQ-027 With no request, rw_wait SHALL be 0 and rd_data SHALL be 0.

Reset
REQ-028 While rst=1, SHALL hold:
- all valid bits cleared;
- FSM=IDLE, cnt=0;
- bus_req=0 and all bus outputs 0;
- rw_wait reflects only the current request, so a read reports a miss.
REQ-029 Reset mid-fill or mid-write SHALL abort the transfer; the partially filled line stays invalid.

Configuration
REQ-030 With macro DATA_CACHE_UNCACHED_EN defined, addr[31]=1 accesses SHALL bypass the cache:
- reads do one single-word bus read, rd_data=bus_rdata, rw_wait=0 on bus_ready, no line update;
- writes go to the bus with no cache update.
REQ-031 Without DATA_CACHE_UNCACHED_EN, addr[31] SHALL be ordinary tag bits.

Verification
REQ-032 Reset, then read 0x100 with bus returning 0xA0..0xA3, bus_ack=1, bus_ready=1 -> bus_rd at 0x100,0x104,0x108,0x10C; rw_wait falls after 4 transfers; rd_data=0xA0.
REQ-033 After REQ-032, read 0x108 -> same-cycle rw_wait=0, rd_data=0xA2, bus_req=0.
REQ-034 Write 0x104 with 0xDEADBEEF, bus_ready delayed 2 cycles -> bus_wr=1, bus_addr=0x104, bus_wdata=0xDEADBEEF; rw_wait=0 on the ready cycle; a following read of 0x104 hits with 0xDEADBEEF.
REQ-035 Read miss with bus_ack=0 for 3 cycles -> bus_req=1, all bus outputs 0, rw_wait=1; the fill proceeds once bus_ack=1.
REQ-036 Read 0x100 (valid), then read 0x500 (same index, new tag) -> miss, refill, line replaced; re-reading 0x100 misses again.
REQ-037 rst pulsed after 2 of 4 fill words -> bus_req=0 immediately; a read of 0x100 then misses and refetches all 4 words.
